// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types for the putc arbiter.
//   arb_state_t : arbiter FSM states
//   CHAR_W      : width of one character on the putc channel
package io_arb_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  : request vector
//   last : index of the most recently granted requester
//   pick : one-hot winner, all zero when req is empty
//   idx  : index of the winner (0 when req is empty)
// The scan starts at last+1 and wraps, so last itself is lowest priority.
module rr_pick
    import io_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int  j;
        logic found;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(last) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/io_putc_arbiter.sv
// io_putc_arbiter: round-robin arbiter sharing one putc channel among
// N_REQ requesters, with optional per-requester lock so multi-character
// messages are not interleaved.
//   clk, rst                 : clock, synchronous active-high reset
//   req_push/req_char/req_lock : per-requester request, character, lock
//   req_done                 : one-cycle pulse, requester's char accepted
//   putc_push/putc_char      : character offered to the I/O device
//   putc_push_done           : device accepted the character (pulse)
//   grant                    : one-hot current owner, zero when none
//   lock_timeout             : pulse, an idle lock was forcibly released
module io_putc_arbiter
    import io_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_push,
    input  logic [N_REQ*CHAR_W-1:0] req_char,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        req_done,
    output logic                    putc_push,
    output logic [CHAR_W-1:0]       putc_char,
    input  logic                    putc_push_done,
    output logic [N_REQ-1:0]        grant,
    output logic                    lock_timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    // A zero timeout still needs a 1-bit counter to keep the logic legal.
    localparam int CNT_W = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t        state, state_n;
    logic [IDX_W-1:0]  owner, owner_n;
    logic [IDX_W-1:0]  last, last_n;
    logic              held, held_n;       // owner left HOLD by dropping its lock
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [N_REQ-1:0]  grant_n, req_done_n;
    logic              putc_push_n, lock_timeout_n;
    logic [CHAR_W-1:0] putc_char_n, owner_char, pick_char;
    logic [N_REQ-1:0]  pick;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req_push),
        .last (last),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign owner_char = req_char[int'(owner) * CHAR_W +: CHAR_W];
    assign pick_char  = req_char[int'(pick_idx) * CHAR_W +: CHAR_W];
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n        = state;
        owner_n        = owner;
        last_n         = last;
        held_n         = held;
        cnt_n          = cnt;
        grant_n        = grant;
        putc_push_n    = putc_push;
        putc_char_n    = putc_char;
        req_done_n     = '0;
        lock_timeout_n = 1'b0;
        case (state)
            ARB: begin
                if (held && req_lock[owner] && req_push[owner]) begin
                    // A relocked former owner resumes ahead of everyone.
                    grant_n        = '0;
                    grant_n[owner] = 1'b1;
                    last_n         = owner;
                    putc_char_n    = owner_char;
                    putc_push_n    = 1'b1;
                    held_n         = 1'b0;
                    state_n        = SEND;
                end else if (|pick) begin
                    grant_n     = pick;
                    owner_n     = pick_idx;
                    last_n      = pick_idx;
                    putc_char_n = pick_char;
                    putc_push_n = 1'b1;
                    held_n      = 1'b0;
                    state_n     = SEND;
                end else begin
                    grant_n = '0;
                end
            end
            SEND: begin
                if (putc_push_done) begin
                    putc_push_n       = 1'b0;
                    req_done_n[owner] = 1'b1;
                    state_n           = DONE;
                end
            end
            DONE: begin
                if (req_lock[owner]) begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    grant_n = '0;
                    state_n = ARB;
                end
            end
            HOLD: begin
                if (req_push[owner]) begin
                    putc_char_n = owner_char;
                    putc_push_n = 1'b1;
                    state_n     = SEND;
                end else if (!req_lock[owner]) begin
                    grant_n = '0;
                    held_n  = 1'b1;
                    state_n = ARB;
                end else begin
                    cnt_n = cnt_inc;
                    if (LOCK_TIMEOUT != 0 && cnt_inc == CNT_LIM) begin
                        // last already points at owner, so it drops to lowest priority.
                        lock_timeout_n = 1'b1;
                        grant_n        = '0;
                        held_n         = 1'b0;
                        state_n        = ARB;
                    end
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            owner        <= '0;
            last         <= IDX_W'(N_REQ - 1);
            held         <= 1'b0;
            cnt          <= '0;
            grant        <= '0;
            putc_push    <= 1'b0;
            putc_char    <= '0;
            req_done     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            last         <= last_n;
            held         <= held_n;
            cnt          <= cnt_n;
            grant        <= grant_n;
            putc_push    <= putc_push_n;
            putc_char    <= putc_char_n;
            req_done     <= req_done_n;
            lock_timeout <= lock_timeout_n;
        end
    end

endmodule

// File: tb/tb_io_putc_arbiter.sv
// Bench for io_putc_arbiter (N_REQ=2, LOCK_TIMEOUT=8). Requester drivers
// feed per-requester character queues; a device model accepts characters
// after a programmable delay and compares them against an expected queue.
module tb_io_putc_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_push;
    logic [15:0] req_char;
    logic [1:0]  req_lock;
    logic [1:0]  req_done;
    logic        putc_push;
    logic [7:0]  putc_char;
    logic        putc_push_done;
    logic [1:0]  grant;
    logic        lock_timeout;

    io_putc_arbiter #(.N_REQ(2), .LOCK_TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_push       (req_push),
        .req_char       (req_char),
        .req_lock       (req_lock),
        .req_done       (req_done),
        .putc_push      (putc_push),
        .putc_char      (putc_char),
        .putc_push_done (putc_push_done),
        .grant          (grant),
        .lock_timeout   (lock_timeout)
    );

    typedef struct {
        logic [7:0] c;
        logic [1:0] g;
    } exp_t;

    int         checks    = 0;
    int         failures  = 0;
    int         delivered = 0;
    int         dev_delay = 1;
    exp_t       sb [$];
    logic [7:0] txq [2][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Requesters: present queue head, advance on req_done.
    initial begin
        req_push = '0;
        req_char = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (req_done[i] && txq[i].size() > 0) void'(txq[i].pop_front());
                if (txq[i].size() > 0) begin
                    req_push[i]        = 1'b1;
                    req_char[i*8 +: 8] = txq[i][0];
                end else begin
                    req_push[i] = 1'b0;
                end
            end
        end
    end

    // Device: accept dev_delay cycles after putc_push is first seen.
    initial begin
        int   dcnt;
        exp_t e;
        dcnt = 0;
        putc_push_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                putc_push_done = 1'b0;
                dcnt = 0;
            end else if (putc_push_done) begin
                putc_push_done = 1'b0;
                dcnt = 0;
            end else if (putc_push) begin
                dcnt++;
                if (dcnt > dev_delay) begin
                    putc_push_done = 1'b1;
                    delivered++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_char got=%02h grant=%b want=none", putc_char, grant);
                    end else begin
                        e = sb.pop_front();
                        if (putc_char !== e.c || grant !== e.g) begin
                            failures++;
                            $display("FAIL char_order got=%02h/%b want=%02h/%b", putc_char, grant, e.c, e.g);
                        end
                    end
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // Structural invariants every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(req_done) || !$onehot0(grant)) begin
                failures++;
                $display("FAIL onehot got req_done=%b grant=%b want onehot0", req_done, grant);
            end
        end
    end

    task automatic push_exp(input logic [7:0] c, input logic [1:0] g);
        exp_t e;
        e.c = c;
        e.g = g;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_lock = '0;
        txq[0].delete();
        txq[1].delete();
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drained(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && txq[0].size() == 0 && txq[1].size() == 0 &&
                !putc_push && req_done == 2'b00) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_lock = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 2'b00 || putc_push !== 1'b0 || putc_char !== 8'h00 ||
            req_done !== 2'b00 || lock_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got g=%b p=%b c=%02h d=%b t=%b want all zero",
                     grant, putc_push, putc_char, req_done, lock_timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int d0;
        dev_delay = 3;
        d0 = delivered;
        @(negedge clk);
        txq[0].push_back(8'h41);
        push_exp(8'h41, 2'b01);
        @(negedge clk);
        checks++;
        if (putc_push !== 1'b0) begin
            failures++;
            $display("FAIL single_early got putc_push=%b want 0", putc_push);
        end
        @(negedge clk);
        checks++;
        if (putc_push !== 1'b1 || putc_char !== 8'h41 || grant !== 2'b01) begin
            failures++;
            $display("FAIL single_latency got p=%b c=%02h g=%b want 1/41/01", putc_push, putc_char, grant);
        end
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (putc_push_done) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_done_wait got no putc_push_done want one");
        end
        @(negedge clk);
        checks++;
        if (req_done !== 2'b01 || putc_push !== 1'b0) begin
            failures++;
            $display("FAIL single_req_done got d=%b p=%b want 01/0", req_done, putc_push);
        end
        @(negedge clk);
        checks++;
        if (req_done !== 2'b00) begin
            failures++;
            $display("FAIL single_pulse got d=%b want 00", req_done);
        end
        wait_drained(20, ok);
        checks++;
        if (!ok || delivered - d0 !== 1) begin
            failures++;
            $display("FAIL single_count got ok=%0d n=%0d want 1/1", ok, delivered - d0);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int d0;
        do_reset();
        dev_delay = 1;
        d0 = delivered;
        txq[0].push_back(8'h41); txq[0].push_back(8'h41);
        txq[1].push_back(8'h42); txq[1].push_back(8'h42);
        push_exp(8'h41, 2'b01); push_exp(8'h42, 2'b10);
        push_exp(8'h41, 2'b01); push_exp(8'h42, 2'b10);
        wait_drained(200, ok);
        checks++;
        if (!ok || delivered - d0 !== 4) begin
            failures++;
            $display("FAIL contention got ok=%0d n=%0d want 1/4", ok, delivered - d0);
        end
    endtask

    task automatic test_lock();
        bit ok;
        bit stray;
        int d0;
        do_reset();
        dev_delay = 1;
        d0 = delivered;
        req_lock[1] = 1'b1;
        txq[1].push_back(8'h4F); txq[1].push_back(8'h4B); txq[1].push_back(8'h0A);
        push_exp(8'h4F, 2'b10); push_exp(8'h4B, 2'b10); push_exp(8'h0A, 2'b10);
        push_exp(8'h78, 2'b01);
        repeat (2) @(negedge clk);
        txq[0].push_back(8'h78);
        ok = 1'b0;
        stray = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (grant !== 2'b10) stray = 1'b1;
            if (txq[1].size() == 0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || stray) begin
            failures++;
            $display("FAIL lock_hold got done=%0d stray_grant=%0d want 1/0", ok, stray);
        end
        req_lock[1] = 1'b0;
        wait_drained(50, ok);
        checks++;
        if (!ok || delivered - d0 !== 4) begin
            failures++;
            $display("FAIL lock_count got ok=%0d n=%0d want 1/4", ok, delivered - d0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        int hold;
        do_reset();
        dev_delay = 0;
        req_lock[1] = 1'b1;
        txq[1].push_back(8'h41);
        push_exp(8'h41, 2'b10);
        push_exp(8'h79, 2'b01);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (txq[1].size() == 0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_setup got no req_done want one");
        end
        txq[0].push_back(8'h79);
        hold = 0;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (lock_timeout) begin seen = 1'b1; break; end
            if (grant == 2'b10 && !putc_push && req_done == 2'b00) hold++;
        end
        checks++;
        if (!seen || hold !== 8 || grant !== 2'b00) begin
            failures++;
            $display("FAIL timeout_pulse got seen=%0d hold=%0d g=%b want 1/8/00", seen, hold, grant);
        end
        @(negedge clk);
        checks++;
        if (lock_timeout !== 1'b0 || grant !== 2'b01 || putc_push !== 1'b1 || putc_char !== 8'h79) begin
            failures++;
            $display("FAIL timeout_regrant got t=%b g=%b p=%b c=%02h want 0/01/1/79",
                     lock_timeout, grant, putc_push, putc_char);
        end
        repeat (4) @(negedge clk);
        req_lock[1] = 1'b0;
        wait_drained(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_drain got not drained want drained");
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit stable;
        int n;
        do_reset();
        dev_delay = 100;
        txq[0].push_back(8'h53);
        txq[1].push_back(8'h54);
        push_exp(8'h53, 2'b01);
        push_exp(8'h54, 2'b10);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (putc_push) begin ok = 1'b1; break; end
        end
        stable = ok;
        n = 0;
        while (ok && !putc_push_done && n < 150) begin
            if (putc_push !== 1'b1 || putc_char !== 8'h53 || grant !== 2'b01 || req_done !== 2'b00)
                stable = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++;
        if (!stable || n < 100) begin
            failures++;
            $display("FAIL stall_stable got stable=%0d cycles=%0d want 1/>=100", stable, n);
        end
        dev_delay = 1;
        wait_drained(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_drain got not drained want drained");
        end
    endtask

    task automatic test_reset_send();
        bit ok;
        do_reset();
        dev_delay = 1000;
        txq[0].push_back(8'h52);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (putc_push) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_send_setup got no putc_push want 1");
        end
        rst = 1'b1;
        txq[0].delete();
        sb.delete();
        @(negedge clk);
        checks++;
        if (putc_push !== 1'b0 || grant !== 2'b00 || req_done !== 2'b00) begin
            failures++;
            $display("FAIL rst_send got p=%b g=%b d=%b want 0/00/00", putc_push, grant, req_done);
        end
        @(negedge clk);
        rst = 1'b0;
        dev_delay = 1;
        txq[1].push_back(8'h62);
        txq[0].push_back(8'h61);
        push_exp(8'h61, 2'b01);
        push_exp(8'h62, 2'b10);
        wait_drained(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_send_prio got not drained want drained");
        end
    endtask

    initial begin
        rst = 1'b1;
        req_lock = '0;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_stall();
        test_reset_send();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL leftover got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_putc_arbiter.md
Name: io_putc_arbiter

Overview:
Shares the single putc channel of the UART I/O device among N_REQ requesters, e.g. CPU core, boot monitor and debug tracer. Selection is round-robin. A requester may hold a lock so that a multi-character message is not interleaved with output from other requesters. The block sits between the requesters and the putc side of the `if_io` server. It sequences one character at a time through the putc_push / putc_push_done handshake.

Parameters:
- N_REQ, 2, number of requesters (range 2..8).
- LOCK_TIMEOUT, 1024, number of idle HOLD cycles before a lock is forcibly released; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_push  in  N_REQ  per requester: a character is pending
- req_char  in  N_REQ*8  per requester: the character; requester i uses bits [8i+7:8i]
- req_lock  in  N_REQ  per requester: keep the grant after the current character completes
- req_done  out  N_REQ  one-cycle pulse: the requester's character was accepted downstream
- putc_push  out  1  to the I/O device: a character is offered
- putc_char  out  8  to the I/O device: the offered character
- putc_push_done  in  1  from the I/O device: one-cycle pulse, the character was accepted
- grant  out  N_REQ  one-hot current owner; all zero when there is no owner
- lock_timeout  out  1  one-cycle pulse: a lock was forcibly released

Behaviour:
- Reset values: state ARB, grant=0, putc_push=0, putc_char=0, req_done=0, lock_timeout=0, timeout counter 0. The round-robin pointer resets to last=N_REQ-1, so requester 0 has top priority.
- Requester contract:
  - Hold req_push high and req_char stable until req_done pulses.
  - The cycle after req_done, the requester either drops req_push or presents its next character.
- States:
  - ARB:
    - Pick the first i with req_push[i], scanning from last+1 with wrap-around.
    - Exception: if an owner is held from HOLD with req_lock[owner] set and req_push[owner] high, that owner is re-granted regardless of other requests.
    - On a pick: register grant, set last=i, latch putc_char=req_char[i], set putc_push=1, go to SEND.
    - No request: stay in ARB with grant=0.
  - SEND:
    - putc_push held high and putc_char held stable.
    - Wait with no bound for putc_push_done.
    - On putc_push_done: putc_push=0 and req_done[owner]=1 at the next edge, then go to DONE.
    - putc_push drops exactly one cycle after putc_push_done. The device guarantees it does not accept again in that cycle.
  - DONE:
    - One cycle; req_done[owner] is high.
    - All requests are ignored.
    - Next state: HOLD if req_lock[owner] is high, else ARB with grant cleared.
  - HOLD:
    - Owner retained and grant stays asserted.
    - If req_push[owner] is high, relatch the character and go to SEND.
    - Else if req_lock[owner] drops, go to ARB with grant cleared.
    - Else increment the timeout counter. When it reaches LOCK_TIMEOUT (LOCK_TIMEOUT≠0): pulse lock_timeout, clear grant, go to ARB. The former owner is now lowest priority.
    - The counter clears on every HOLD entry.
- Latency:
  - putc_push rises 1 cycle after req_push is sampled in ARB.
  - req_done rises 1 cycle after putc_push_done.
  - The minimum cost per character is 3 cycles plus the device's acceptance delay.
- Boundary conditions:
  - Simultaneous req_push on every input: strict rotation, one character each.
  - req_push dropped by the owner while in SEND: a protocol violation. The character is still delivered and req_done still pulses.
  - Reset mid-SEND: putc_push falls at the next edge and req_done is not issued. The character may or may not have been accepted downstream; this is accepted as a loss.
  - At most one req_done bit is high at any time, and grant is always zero or one-hot.
  - The timeout counter width is clog2(LOCK_TIMEOUT+1) and it saturates; it must not wrap.

Decomposition:
- Package io_arb_pkg: state enum (ARB, SEND, DONE, HOLD) and a constant CHAR_W=8.
- Sub-module rr_pick: purely combinational. Inputs are the request vector and the last pointer; outputs are the one-hot pick and its index.
- The FSM, output registers and timeout counter stay in io_putc_arbiter.

Test Plan:
- Single character: req_push[0] with 0x41; device sends putc_push_done 3 cycles after putc_push → putc_push and 0x41 appear the cycle after the request, req_done[0] is a single pulse one cycle after done, and exactly one character is delivered.
- Contention from reset: requesters 0 and 1 both hold requests, sending 0x41 and 0x42, two characters each → output order 0x41, 0x42, 0x41, 0x42, and grant alternates 01, 10, 01, 10.
- Lock: requester 1 holds req_lock and sends "OK\n" while requester 0 is pending with 'x' → output is "OK\n" then 'x', and grant stays 10 through the three characters.
- Lock timeout with LOCK_TIMEOUT=8: requester 1 is locked and idle for 12 cycles while requester 0 is pending → lock_timeout pulses on the 8th HOLD cycle, and requester 0 is granted in the next ARB.
- Device stall: putc_push_done is withheld for 100 cycles → putc_push and putc_char stay stable throughout, no req_done is issued early, and other requesters are not granted.
- Reset asserted in SEND → the next cycle shows putc_push=0, grant=0 and req_done=0; after reset requester 0 has top priority.
